alu_share_arbiter: RTL and testbench

Controller that shares one combinational yAlu-style 32-bit ALU between two requesters. It round-robin arbitrates requests, registers the operands, and drives the ALU for a programmable number of settle cycles. It then captures the result and zero flag and returns them on a single tagged response channel with valid/ready backpressure. It sits between datapath clients (e.g. the address unit and the branch-compare unit) and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. Requests are
// round-robin arbitrated, held for EXEC_CYCLES settle cycles, and answered on one tagged channel.
module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_zero,
    output logic             busy
);
    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             last_grant;
    logic             grant_id, grant_any, accept, op_legal, exec_done;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic             id_q, zero_q, err_q;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else
            grant_id = req1_valid;
        sel_op = grant_id ? req1_op : req0_op;
        sel_a  = grant_id ? req1_a  : req0_a;
        sel_b  = grant_id ? req1_b  : req0_b;
        case (sel_op)
            3'd0, 3'd1, 3'd2, 3'd6, 3'd7: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
        accept    = (state == IDLE) && grant_any && !rst;
        exec_done = (cnt == CW'(EXEC_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = op_legal ? EXEC : RESP;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // Illegal ops leave the ALU-facing registers alone so the ALU sees no activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            data_q     <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            id_q       <= grant_id;
            last_grant <= grant_id;
            cnt        <= '0;
            if (op_legal) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
            end else begin
                data_q <= '0;
                zero_q <= 1'b0;
                err_q  <= 1'b1;
            end
        end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
            if (exec_done) begin
                data_q <= alu_z;
                zero_q <= alu_zero;
                err_q  <= 1'b0;
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one instance with a single settle cycle, one with three,
// each wired to a small behavioural ALU.
module tb_alu_share_arbiter;
    logic clk, rst, s_rst;
    int   checks, errors, n;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_z;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, alu_zero, busy;

    logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
    logic [2:0]  s_req0_op, s_req1_op, s_alu_op;
    logic [31:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b, s_rsp_data, s_alu_a, s_alu_b, s_alu_z;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_zero, s_rsp_err, s_alu_zero, s_busy;

    int          gcnt, rcnt;
    int          gid[4], gcyc[4], rid[4];
    logic [31:0] rdat[4];
    logic        seen;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return {31'b0, $signed(a) < $signed(b)};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_z      = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_z == 32'h0);
    assign s_alu_z    = alu_f(s_alu_op, s_alu_a, s_alu_b);
    assign s_alu_zero = (s_alu_z == 32'h0);

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_zero(alu_zero), .busy(busy));

    alu_share_arbiter #(.WIDTH(32), .EXEC_CYCLES(3)) u_slow (
        .clk(clk), .rst(s_rst),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(s_req0_op), .req0_a(s_req0_a), .req0_b(s_req0_b),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_op(s_req1_op), .req1_a(s_req1_a), .req1_b(s_req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
        .rsp_zero(s_rsp_zero), .rsp_err(s_rsp_err),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_z(s_alu_z), .alu_zero(s_alu_zero), .busy(s_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One isolated request on the fast instance, with rsp_ready held high.
    task automatic do_req(input string tag, input logic id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                          input logic z, input logic e, input int lat);
        int k;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1 chk({tag, "_rdy"}, {30'b0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_id"}, {31'b0, rsp_id}, {31'b0, id});
        chk({tag, "_data"}, rsp_data, d);
        chk({tag, "_zero"}, {31'b0, rsp_zero}, {31'b0, z});
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e});
        @(negedge clk);
        chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        chk({tag, "_vld_after"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; s_rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_op = 3'd0; req1_a = '0; req1_b = '0;
        s_req0_valid = 1'b0; s_req1_valid = 1'b0; s_rsp_ready = 1'b0;
        s_req0_op = 3'd0; s_req0_a = '0; s_req0_b = '0;
        s_req1_op = 3'd0; s_req1_a = '0; s_req1_b = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("rst_vld", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_flags", {29'b0, rsp_id, rsp_zero, rsp_err}, 32'd0);
        chk("rst_alu", alu_a | alu_b | {29'b0, alu_op}, 32'd0);
        chk("rst_s_busy", {31'b0, s_busy}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;

        do_req("add", 1'b0, 3'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2);
        do_req("sub", 1'b1, 3'd6, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 2);
        do_req("slt", 1'b0, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 2);
        do_req("and", 1'b0, 3'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1, 1'b0, 2);

        // Re-reset so the first tie goes to req0, then keep both requesting.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'd2; req1_b = 32'd4;
        rsp_ready = 1'b1;
        gcnt = 0; rcnt = 0;
        for (int c = 0; c < 60 && (gcnt < 4 || rcnt < 4); c++) begin
            #1;
            if ((req0_ready || req1_ready) && gcnt < 4) begin
                gid[gcnt] = int'(req1_ready); gcyc[gcnt] = c; gcnt++;
            end
            if (rsp_valid && rcnt < 4) begin
                rid[rcnt] = int'(rsp_id); rdat[rcnt] = rsp_data; rcnt++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_grants", gcnt, 4);
        chk("rr_rsps", rcnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_gid", gid[i], i % 2);
            chk("rr_rid", rid[i], i % 2);
            chk("rr_data", rdat[i], (i % 2) ? 32'd6 : 32'd2);
            if (i > 0) chk("rr_space", gcyc[i] - gcyc[i-1], 3);
        end
        repeat (2) @(negedge clk);

        do_req("ill", 1'b0, 3'd3, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1);
        chk("ill_alu_op", {29'b0, alu_op}, 32'd1);
        chk("ill_alu_a", alu_a, 32'd2);
        chk("ill_alu_b", alu_b, 32'd4);
        do_req("post_ill", 1'b1, 3'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 2);

        // Slow instance: three settle cycles, then a stalled response.
        @(negedge clk);
        s_rsp_ready = 1'b0;
        s_req0_valid = 1'b1; s_req0_op = 3'd2; s_req0_a = 32'd10; s_req0_b = 32'd20;
        s_req1_op = 3'd1; s_req1_a = 32'd1; s_req1_b = 32'd2;
        #1 chk("s_rdy", {31'b0, s_req0_ready}, 32'd1);
        @(negedge clk);
        s_req0_valid = 1'b0;
        n = 1;
        while (!s_rsp_valid && n < 20) begin
            chk("s_exec_op", {29'b0, s_alu_op}, 32'd2);
            chk("s_exec_a", s_alu_a, 32'd10);
            @(negedge clk);
            n++;
        end
        chk("s_lat", n, 4);
        s_req0_valid = 1'b1; s_req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s_hold_vld", {31'b0, s_rsp_valid}, 32'd1);
            chk("s_hold_data", s_rsp_data, 32'd30);
            chk("s_hold_rdy", {30'b0, s_req1_ready, s_req0_ready}, 32'd0);
            @(negedge clk);
        end
        s_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("s_resume_rdy", {30'b0, s_req1_ready, s_req0_ready}, 32'd2);
        chk("s_resume_vld", {31'b0, s_rsp_valid}, 32'd0);
        @(negedge clk);
        s_req0_valid = 1'b0; s_req1_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Async reset in the middle of an EXEC window drops the op.
        s_req0_valid = 1'b1; s_req0_op = 3'd2; s_req0_a = 32'd5; s_req0_b = 32'd5;
        @(negedge clk);
        s_req0_valid = 1'b0;
        chk("ar_busy_pre", {31'b0, s_busy}, 32'd1);
        #2 s_rst = 1'b1;
        #1;
        chk("ar_busy", {31'b0, s_busy}, 32'd0);
        chk("ar_vld", {31'b0, s_rsp_valid}, 32'd0);
        chk("ar_alu", s_alu_a | s_alu_b | {29'b0, s_alu_op}, 32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 if (s_rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("ar_no_rsp", {31'b0, seen}, 32'd0);
        s_req0_valid = 1'b1; s_req1_valid = 1'b1;
        #1 chk("ar_tie", {30'b0, s_req1_ready, s_req0_ready}, 32'd1);
        @(negedge clk);
        s_req0_valid = 1'b0; s_req1_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
